// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB destinations, selects operand forwarding,
// inserts a single bubble on load-use and counts those stall cycles.
module hazard_ctrl #(
    parameter int         CNT_W       = 16,
    parameter logic [1:0] RF_WSEL_RDO = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_we,
    input  logic [1:0]       id_rf_wsel,
    input  logic             flush,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int STAGES = 2;  // index 0 = EX, 1 = MEM, 2 = WB

    typedef struct packed {
        logic [4:0] rd;
        logic       ld;
    } trk_t;

    logic [STAGES:0]       vld_pipe;
    trk_t [STAGES:0]       trk_pipe;
    logic                  load_use;
    logic                  issue;
    trk_t                  trk_new;

    function automatic logic hit(input logic v, input trk_t t,
                                 input logic [4:0] rs, input logic used);
        return v && (t.rd == rs) && (rs != 5'd0) && used;
    endfunction

    // Walk oldest to youngest so the youngest matching stage wins.
    function automatic logic [1:0] pick(input logic [STAGES:0] v, input trk_t [STAGES:0] t,
                                        input logic [4:0] rs, input logic used);
        logic [1:0] sel;
        sel = 2'b00;
        for (int s = STAGES; s >= 0; s--)
            if (hit(v[s], t[s], rs, used))
                sel = 2'(s + 1);
        return sel;
    endfunction

    always_comb begin
        load_use  = id_valid && !flush && trk_pipe[0].ld &&
                    (hit(vld_pipe[0], trk_pipe[0], id_rs1, id_rs1_used) ||
                     hit(vld_pipe[0], trk_pipe[0], id_rs2, id_rs2_used));
        stall_id  = mem_busy || load_use;
        bubble_ex = load_use && !mem_busy;
        fwd1_sel  = id_valid ? pick(vld_pipe, trk_pipe, id_rs1, id_rs1_used) : 2'b00;
        fwd2_sel  = id_valid ? pick(vld_pipe, trk_pipe, id_rs2, id_rs2_used) : 2'b00;
        issue     = id_valid && id_rf_we && (id_rd != 5'd0) && !flush && !load_use;
        trk_new   = issue ? '{rd: id_rd, ld: (id_rf_wsel == RF_WSEL_RDO)} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            trk_pipe  <= '0;
            stall_cnt <= '0;
        end else begin
            if (!mem_busy) begin
                vld_pipe <= {vld_pipe[STAGES-1:0], issue};
                trk_pipe <= {trk_pipe[STAGES-1:0], trk_new};
            end
            if (cnt_clr)
                stall_cnt <= '0;
            else if (bubble_ex && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle comparison against a history-queue model,
// plus hand-computed literal checks for each scenario.
module tb_hazard_ctrl;
    localparam int         CW  = 4;
    localparam logic [1:0] RDO = 2'b01;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs1_used, id_rs2_used, id_rf_we, flush, mem_busy, cnt_clr;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic [1:0]    id_rf_wsel;
    logic          stall_id, bubble_ex;
    logic [1:0]    fwd1_sel, fwd2_sel;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl #(.CNT_W(CW), .RF_WSEL_RDO(RDO)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_rf_we(id_rf_we), .id_rf_wsel(id_rf_wsel), .flush(flush), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: history of what entered EX on each advancing cycle, youngest first.
    typedef struct {
        bit         v;
        logic [4:0] rd;
        bit         ld;
    } slot_t;
    slot_t hist[$];
    int    m_cnt;

    task automatic model_reset();
        slot_t z;
        z.v = 0; z.rd = 5'd0; z.ld = 0;
        hist.delete();
        repeat (3) hist.push_back(z);
        m_cnt = 0;
    endtask

    function automatic bit m_hit(input int age, input logic [4:0] rs, input bit used);
        return hist[age].v && hist[age].rd == rs && rs != 5'd0 && used;
    endfunction

    function automatic bit m_lu();
        return id_valid && !flush && hist[0].ld &&
               (m_hit(0, id_rs1, id_rs1_used) || m_hit(0, id_rs2, id_rs2_used));
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs, input bit used);
        if (!id_valid) return 2'b00;
        for (int a = 0; a < 3; a++)
            if (m_hit(a, rs, used)) return 2'(a + 1);
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        bit    lu;
        slot_t s;
        if (rst) begin
            model_reset();
        end else begin
            lu = m_lu();
            if (cnt_clr) m_cnt = 0;
            else if (lu && !mem_busy && m_cnt < (1 << CW) - 1) m_cnt++;
            if (!mem_busy) begin
                s.v  = id_valid && id_rf_we && id_rd != 5'd0 && !flush && !lu;
                s.rd = s.v ? id_rd : 5'd0;
                s.ld = s.v && (id_rf_wsel == RDO);
                hist.push_front(s);
                void'(hist.pop_back());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_stall_id",  32'(stall_id),  32'(m_lu() || mem_busy));
            chk("m_bubble_ex", 32'(bubble_ex), 32'(m_lu() && !mem_busy));
            chk("m_fwd1_sel",  32'(fwd1_sel),  32'(m_fwd(id_rs1, id_rs1_used)));
            chk("m_fwd2_sel",  32'(fwd2_sel),  32'(m_fwd(id_rs2, id_rs2_used)));
            chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end
    end

    task automatic cyc(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                       input bit u1, input bit u2, input logic [4:0] d, input bit we,
                       input bit ld, input bit fl, input bit mb, input bit clr);
        @(posedge clk); #1;
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = d; id_rf_we = we; id_rf_wsel = ld ? RDO : 2'b00;
        flush = fl; mem_busy = mb; cnt_clr = clr;
    endtask

    task automatic idle(input bit mb);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, mb, 0);
    endtask

    task automatic settle();
        #5;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_rf_we = 0; id_rf_wsel = 0; flush = 0; mem_busy = 0; cnt_clr = 0;
        @(posedge clk); @(posedge clk); #1; rst = 1'b0;

        // Reset state, with a reader present
        cyc(1, 5, 6, 1, 1, 0, 0, 0, 0, 0, 0); settle();
        chk("rst_stall", 32'(stall_id), 0);
        chk("rst_bubble", 32'(bubble_ex), 0);
        chk("rst_fwd1", 32'(fwd1_sel), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);

        // add x5 ; add x6,x5,x5
        cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0);
        cyc(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0); settle();
        chk("alu_fwd1", 32'(fwd1_sel), 1);
        chk("alu_fwd2", 32'(fwd2_sel), 1);
        chk("alu_stall", 32'(stall_id), 0);

        // lw x7 ; add x8,x7,x0
        cyc(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 0); settle();
        chk("lu_stall", 32'(stall_id), 1);
        chk("lu_bubble", 32'(bubble_ex), 1);
        chk("lu_cnt0", 32'(stall_cnt), 0);
        cyc(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 0); settle();
        chk("lu_fwd1_mem", 32'(fwd1_sel), 2);
        chk("lu_fwd2_x0", 32'(fwd2_sel), 0);
        chk("lu_release", 32'(stall_id), 0);
        chk("lu_cnt1", 32'(stall_cnt), 1);

        // lw x9 ; dependent writer of x10 killed by flush
        cyc(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);
        cyc(1, 9, 0, 1, 0, 10, 1, 0, 1, 0, 0); settle();
        chk("fl_stall", 32'(stall_id), 0);
        chk("fl_bubble", 32'(bubble_ex), 0);
        cyc(1, 9, 10, 1, 1, 0, 0, 0, 0, 0, 0); settle();
        chk("fl_fwd1_mem", 32'(fwd1_sel), 2);
        chk("fl_fwd2_none", 32'(fwd2_sel), 0);
        chk("fl_cnt", 32'(stall_cnt), 1);

        // producer x11 reaches WB, then 3 cycles of mem_busy
        cyc(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0);
        idle(0); idle(0);
        repeat (3) begin
            idle(1); settle();
            chk("mb_stall", 32'(stall_id), 1);
            chk("mb_bubble", 32'(bubble_ex), 0);
        end
        cyc(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("mb_fwd_wb", 32'(fwd1_sel), 3);

        // writes to x0 (alu and load), then reader of x0
        cyc(1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0); settle();
        chk("x0_fwd1", 32'(fwd1_sel), 0);
        chk("x0_fwd2", 32'(fwd2_sel), 0);
        chk("x0_stall", 32'(stall_id), 0);

        // saturate the counter (currently 1), then clear against a load-use
        repeat (14) begin
            cyc(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
            cyc(1, 0, 7, 0, 1, 8, 1, 0, 0, 0, 0);
        end
        cyc(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); settle();
        chk("sat_full", 32'(stall_cnt), 15);
        cyc(1, 0, 7, 0, 1, 8, 1, 0, 0, 0, 0); settle();
        chk("sat_bubble", 32'(bubble_ex), 1);
        cyc(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); settle();
        chk("sat_hold", 32'(stall_cnt), 15);
        cyc(1, 0, 7, 0, 1, 8, 1, 0, 0, 0, 1); settle();
        chk("clr_bubble", 32'(bubble_ex), 1);
        idle(0); settle();
        chk("clr_cnt", 32'(stall_cnt), 0);

        // reset in the middle of a load-use stall
        cyc(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0);
        cyc(1, 13, 0, 1, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("rs_stall", 32'(stall_id), 1);
        @(posedge clk); #1; rst = 1'b1;
        cyc(1, 12, 13, 1, 1, 0, 0, 0, 0, 0, 0); rst = 1'b0; settle();
        chk("rs_fwd1", 32'(fwd1_sel), 0);
        chk("rs_fwd2", 32'(fwd2_sel), 0);
        chk("rs_stall0", 32'(stall_id), 0);
        chk("rs_cnt", 32'(stall_cnt), 0);

        // reset while mem_busy holds a producer
        cyc(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0);
        idle(1);
        @(posedge clk); #1; rst = 1'b1;
        cyc(1, 14, 0, 1, 0, 0, 0, 0, 0, 0, 0); rst = 1'b0; settle();
        chk("rsmb_fwd1", 32'(fwd1_sel), 0);

        idle(0); idle(0);
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
